usb_in_arbiter: RTL and testbench
=================================

Name: usb_in_arbiter

Overview:
- Shares the single IN-endpoint port of the USB packet engine between N_REQ endpoint sources (HID report, audio feedback, etc.).
- Each source uses the standard IN handshake (Data/Ready/WaitRequest/Ack/Sequence).
- The arbiter grants one source at a time, round-robin. The grant is held from the first byte until the packet completes (Ack), is released (isochronous), or times out. Error retries stay with the same source.
- Sits between the endpoint sources and the packet engine.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ACK_TIMEOUT, 4096, Clk cycles to wait for Ack/Error after Ready falls before forcing release
- TW, $clog2(ACK_TIMEOUT+1), timeout counter width (derived, localparam)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- Req_Data  in  8*N_REQ  byte i at [8i+7:8i]
- Req_Ready  in  N_REQ  source i has a byte valid / packet in progress
- Req_ZeroLength  in  N_REQ  source i sends a zero-length packet
- Req_Isochronous  in  N_REQ  source i is isochronous (no Ack expected)
- Req_Sequence  in  N_REQ  DATA0/1 toggle owned by source i
- Req_WaitRequest  out  N_REQ  stall to source i
- Req_Ack  out  N_REQ  Ack forwarded to granted source only
- Req_Error  out  N_REQ  Error forwarded to granted source only
- IN_Data  out  8  to packet engine
- IN_Ready  out  1
- IN_ZeroLength  out  1
- IN_Isochronous  out  1
- IN_Sequence  out  1
- IN_WaitRequest  in  1  from packet engine
- IN_Ack  in  1  host ACK received (1-cycle pulse)
- Error  in  1  packet engine error/retry (1-cycle pulse)
- Grant  out  $clog2(N_REQ)  index of current/last grant
- Busy  out  1  state != IDLE
- Timeout  out  1  1-cycle pulse on forced release

Behaviour:
- Reset (async, Reset=0): state IDLE, Grant=0, last-grant pointer = N_REQ-1 (so source 0 wins first), timer=0, Timeout=0. Comb outputs in IDLE: IN_Ready=0, Req_WaitRequest=all 1, Req_Ack=0, Req_Error=0.
- Output muxing: IN_Data, IN_ZeroLength, IN_Isochronous and IN_Sequence are combinational muxes of source Grant, with zero latency.
  - IN_Ready = Req_Ready[Grant] in SEND, else 0.
  - Req_WaitRequest[i] = IN_WaitRequest when i==Grant and state==SEND, else 1.
  - Req_Ack[i] = IN_Ack when i==Grant and state==WAIT_ACK, else 0.
  - Req_Error[i] = Error when i==Grant and state!=IDLE, else 0.
- States:
  - IDLE: if any Req_Ready, register Grant = first asserted index scanning upward from last+1, wrapping. Go to SEND next cycle; 1 cycle of arbitration latency.
  - SEND: on Req_Ready[Grant] low:
    - if Req_Isochronous[Grant], go to IDLE and last=Grant;
    - else go to WAIT_ACK with timer=0.
    - Error in SEND is forwarded only; the state is unchanged.
  - WAIT_ACK: timer increments each cycle.
    - Error: forward, stay, timer=0.
    - Req_Ready[Grant] high again (retry): go to SEND.
    - IN_Ack (no Error): forward, go to IDLE, last=Grant.
    - timer==ACK_TIMEOUT-1: Timeout=1 for one cycle, go to IDLE, last=Grant.
- Simultaneous events:
  - Error and IN_Ack in the same cycle: Error wins, no Ack forwarded.
  - Ack and timeout in the same cycle: Ack wins, no Timeout.
  - Req_Ready of other sources during a grant: ignored; those sources see WaitRequest=1.
- The arbiter never toggles Sequence; each source owns its toggle.
- Reset asserted mid-packet: immediate return to IDLE; the in-flight packet is abandoned.
- Grant is stable for the whole of SEND/WAIT_ACK.

Decomposition:
- Shared package usb_pkg: state encoding (IDLE, SEND, WAIT_ACK), default ACK_TIMEOUT.
- One sub-module, rr_pick: combinational round-robin next-index finder (request vector + last index -> index, valid).

Test Plan:
- Single source 0 sends 3 bytes 01,05,00 with IN_WaitRequest=0, then IN_Ack -> Grant=0, IN_Data sequence 01,05,00, Req_Ack[0] pulses once, Busy falls the cycle after Ack.
- Sources 1 and 2 raise Ready in the same cycle after reset -> source 1 served first, then 2; next simultaneous 1 and 2 request -> 1 again (last=2 wraps).
- Source 0 packet, Error pulse in WAIT_ACK, source re-raises Ready -> Grant stays 0, Req_Error[0] single pulse, bytes resent, source 3 Ready meanwhile sees WaitRequest=1 throughout.
- Isochronous source 2, Ready drops with no Ack -> IDLE the next cycle, Req_Ack all 0, no Timeout.
- ACK_TIMEOUT=16, no Ack/Error after Ready falls -> Timeout pulse 16 cycles after entering WAIT_ACK, pending source 1 granted on the following cycle.
- Reset pulled low mid-SEND with IN_WaitRequest=1 -> IN_Ready=0 and Busy=0 asynchronously; after release, source 0 wins first.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB IN-endpoint arbiter: FSM encoding and the
// default Ack/Error wait limit.
package usb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } arb_state_e;

    localparam int ACK_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/usb_in_arbiter_rr_pick.sv
// Combinational round-robin finder: returns the first requester at or above
// last_i+1 (wrapping), plus a valid flag when any request is present.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // cand[k] is the index visited k+1 steps after the last winner
    logic [IW-1:0] cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = IW'((32'(last_i) + 32'(gi) + 32'd1) % 32'(N));
        end
    endgenerate

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[cand[k]]) begin
                idx_o   = cand[k];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter sharing the packet engine's single IN port between
// N_REQ endpoint sources; a grant is held until Ack, isochronous end or timeout.
import usb_pkg::*;

module usb_in_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [8*N_REQ-1:0]         Req_Data,
    input  logic [N_REQ-1:0]           Req_Ready,
    input  logic [N_REQ-1:0]           Req_ZeroLength,
    input  logic [N_REQ-1:0]           Req_Isochronous,
    input  logic [N_REQ-1:0]           Req_Sequence,
    output logic [N_REQ-1:0]           Req_WaitRequest,
    output logic [N_REQ-1:0]           Req_Ack,
    output logic [N_REQ-1:0]           Req_Error,
    output logic [7:0]                 IN_Data,
    output logic                       IN_Ready,
    output logic                       IN_ZeroLength,
    output logic                       IN_Isochronous,
    output logic                       IN_Sequence,
    input  logic                       IN_WaitRequest,
    input  logic                       IN_Ack,
    input  logic                       Error,
    output logic [$clog2(N_REQ)-1:0]   Grant,
    output logic                       Busy,
    output logic                       Timeout
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;

    logic [GW-1:0] pick_idx;
    logic          pick_valid;
    logic [7:0]    req_byte [N_REQ];

    rr_pick #(
        .N  (N_REQ),
        .IW (GW)
    ) u_rr_pick (
        .req_i   (Req_Ready),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_src
            logic is_gnt;
            assign is_gnt              = (grant_q == GW'(gi));
            assign req_byte[gi]        = Req_Data[8*gi +: 8];
            assign Req_WaitRequest[gi] = (is_gnt && state_q == ST_SEND) ? IN_WaitRequest : 1'b1;
            // Error takes precedence: a retried packet must not also look acknowledged
            assign Req_Ack[gi]         = is_gnt && (state_q == ST_WAIT_ACK) && IN_Ack && !Error;
            assign Req_Error[gi]       = is_gnt && (state_q != ST_IDLE) && Error;
        end
    endgenerate

    assign IN_Data        = req_byte[grant_q];
    assign IN_ZeroLength  = Req_ZeroLength[grant_q];
    assign IN_Isochronous = Req_Isochronous[grant_q];
    assign IN_Sequence    = Req_Sequence[grant_q];
    assign IN_Ready       = (state_q == ST_SEND) && Req_Ready[grant_q];
    assign Grant          = grant_q;
    assign Busy           = (state_q != ST_IDLE);
    assign Timeout        = timeout_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!Req_Ready[grant_q]) begin
                    if (Req_Isochronous[grant_q]) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end else begin
                        state_d = ST_WAIT_ACK;
                        timer_d = '0;
                    end
                end
            end
            ST_WAIT_ACK: begin
                timer_d = timer_q + TW'(1);
                if (Error) begin
                    timer_d = '0;
                end else if (Req_Ready[grant_q]) begin
                    state_d = ST_SEND;
                end else if (IN_Ack) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                    last_d    = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset leaves last at N_REQ-1 so source 0 wins the first arbitration
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= GW'(N_REQ - 1);
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Directed bench for usb_in_arbiter (4 sources, ACK_TIMEOUT=16).
module tb_usb_in_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Req_Data = '0;
    logic [3:0]  Req_Ready = '0;
    logic [3:0]  Req_ZeroLength = '0;
    logic [3:0]  Req_Isochronous = '0;
    logic [3:0]  Req_Sequence = '0;
    logic [3:0]  Req_WaitRequest;
    logic [3:0]  Req_Ack;
    logic [3:0]  Req_Error;
    logic [7:0]  IN_Data;
    logic        IN_Ready;
    logic        IN_ZeroLength;
    logic        IN_Isochronous;
    logic        IN_Sequence;
    logic        IN_WaitRequest = 1'b0;
    logic        IN_Ack = 1'b0;
    logic        Error = 1'b0;
    logic [1:0]  Grant;
    logic        Busy;
    logic        Timeout;

    int checks = 0;
    int errors = 0;

    usb_in_arbiter #(.N_REQ(4), .ACK_TIMEOUT(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Data(Req_Data), .Req_Ready(Req_Ready), .Req_ZeroLength(Req_ZeroLength),
        .Req_Isochronous(Req_Isochronous), .Req_Sequence(Req_Sequence),
        .Req_WaitRequest(Req_WaitRequest), .Req_Ack(Req_Ack), .Req_Error(Req_Error),
        .IN_Data(IN_Data), .IN_Ready(IN_Ready), .IN_ZeroLength(IN_ZeroLength),
        .IN_Isochronous(IN_Isochronous), .IN_Sequence(IN_Sequence),
        .IN_WaitRequest(IN_WaitRequest), .IN_Ack(IN_Ack), .Error(Error),
        .Grant(Grant), .Busy(Busy), .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (Grant !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", Grant); end
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", Timeout); end
        checks++; if (Req_WaitRequest !== 4'hF) begin errors++; $display("FAIL reset_waitreq got %b exp 1111", Req_WaitRequest); end
        checks++; if (IN_Ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", IN_Ready); end
        tick();
        Reset = 1'b1;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_single();
        logic [7:0] bytes [3];
        bytes = '{8'h01, 8'h05, 8'h00};
        Req_Data[7:0] = bytes[0];
        Req_Ready = 4'b0001;
        #1;
        checks++; if (IN_Ready !== 1'b0 || Req_WaitRequest !== 4'hF) begin errors++; $display("FAIL single_idle got rdy=%b wr=%b exp rdy=0 wr=1111", IN_Ready, Req_WaitRequest); end
        tick();
        for (int k = 0; k < 3; k++) begin
            Req_Data[7:0] = bytes[k];
            #1;
            checks++; if (IN_Data !== bytes[k] || IN_Ready !== 1'b1 || Grant !== 2'd0 || Req_WaitRequest !== 4'b1110) begin
                errors++; $display("FAIL single_byte%0d got data=%h rdy=%b g=%0d wr=%b exp data=%h rdy=1 g=0 wr=1110", k, IN_Data, IN_Ready, Grant, Req_WaitRequest, bytes[k]);
            end
            tick();
        end
        Req_Ready = 4'b0000;
        tick();
        IN_Ack = 1'b1;
        #1;
        checks++; if (Req_Ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b exp 0001", Req_Ack); end
        tick();
        IN_Ack = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || Req_Ack !== 4'b0000) begin errors++; $display("FAIL single_done got busy=%b ack=%b exp 0 0000", Busy, Req_Ack); end
        $display("txn single src0 3 bytes acked");
    endtask

    task automatic test_round_robin();
        pulse_reset();
        Req_Data[15:8]  = 8'hAA;
        Req_Data[23:16] = 8'hBB;
        Req_Ready = 4'b0110;
        tick();
        #1;
        checks++; if (Grant !== 2'd1 || IN_Data !== 8'hAA || Req_WaitRequest !== 4'b1101) begin errors++; $display("FAIL rr_first got g=%0d d=%h wr=%b exp 1 aa 1101", Grant, IN_Data, Req_WaitRequest); end
        tick();
        Req_Ready = 4'b0100;
        tick();
        #1;
        checks++; if (Grant !== 2'd1 || Busy !== 1'b1 || Req_WaitRequest !== 4'hF) begin errors++; $display("FAIL rr_wait got g=%0d busy=%b wr=%b exp 1 1 1111", Grant, Busy, Req_WaitRequest); end
        IN_Ack = 1'b1;
        tick();
        IN_Ack = 1'b0;
        tick();
        #1;
        checks++; if (Grant !== 2'd2 || IN_Data !== 8'hBB || IN_Ready !== 1'b1) begin errors++; $display("FAIL rr_second got g=%0d d=%h rdy=%b exp 2 bb 1", Grant, IN_Data, IN_Ready); end
        tick();
        Req_Ready = 4'b0000;
        tick();
        IN_Ack = 1'b1;
        tick();
        IN_Ack = 1'b0;
        Req_Ready = 4'b0110;
        tick();
        #1;
        checks++; if (Grant !== 2'd1) begin errors++; $display("FAIL rr_wrap got g=%0d exp 1", Grant); end
        Req_Ready = 4'b0000;
        tick();
        IN_Ack = 1'b1;
        tick();
        IN_Ack = 1'b0;
        $display("txn round robin 1,2,1");
    endtask

    task automatic test_error_retry();
        pulse_reset();
        Req_Data[7:0]   = 8'h11;
        Req_Data[31:24] = 8'h33;
        Req_Ready = 4'b1001;
        tick();
        for (int k = 0; k < 2; k++) begin
            Req_Data[7:0] = (k == 0) ? 8'h11 : 8'h22;
            #1;
            checks++; if (Grant !== 2'd0 || Req_WaitRequest !== 4'b1110 || IN_Data !== Req_Data[7:0]) begin errors++; $display("FAIL err_send%0d got g=%0d wr=%b d=%h exp 0 1110 %h", k, Grant, Req_WaitRequest, IN_Data, Req_Data[7:0]); end
            tick();
        end
        Req_Ready = 4'b1000;
        tick();
        Error  = 1'b1;
        IN_Ack = 1'b1;
        #1;
        checks++; if (Req_Error !== 4'b0001 || Req_Ack !== 4'b0000) begin errors++; $display("FAIL err_pulse got err=%b ack=%b exp 0001 0000", Req_Error, Req_Ack); end
        tick();
        Error  = 1'b0;
        IN_Ack = 1'b0;
        #1;
        checks++; if (Req_Error !== 4'b0000 || Busy !== 1'b1 || Grant !== 2'd0 || Req_WaitRequest !== 4'hF) begin errors++; $display("FAIL err_hold got err=%b busy=%b g=%0d wr=%b exp 0000 1 0 1111", Req_Error, Busy, Grant, Req_WaitRequest); end
        Req_Data[7:0] = 8'h11;
        Req_Ready = 4'b1001;
        tick();
        #1;
        checks++; if (Grant !== 2'd0 || IN_Ready !== 1'b1 || IN_Data !== 8'h11 || Req_WaitRequest !== 4'b1110) begin errors++; $display("FAIL err_resend got g=%0d rdy=%b d=%h wr=%b exp 0 1 11 1110", Grant, IN_Ready, IN_Data, Req_WaitRequest); end
        tick();
        Req_Data[7:0] = 8'h22;
        tick();
        Req_Ready = 4'b1000;
        tick();
        IN_Ack = 1'b1;
        #1;
        checks++; if (Req_Ack !== 4'b0001) begin errors++; $display("FAIL err_final_ack got %b exp 0001", Req_Ack); end
        tick();
        IN_Ack = 1'b0;
        tick();
        #1;
        checks++; if (Grant !== 2'd3 || IN_Data !== 8'h33) begin errors++; $display("FAIL err_next got g=%0d d=%h exp 3 33", Grant, IN_Data); end
        Req_Ready = 4'b0000;
        tick();
        IN_Ack = 1'b1;
        tick();
        IN_Ack = 1'b0;
        $display("txn error retry src0 then src3");
    endtask

    task automatic test_isochronous();
        Req_Isochronous = 4'b0100;
        Req_Ready = 4'b0100;
        tick();
        #1;
        checks++; if (Grant !== 2'd2 || IN_Isochronous !== 1'b1) begin errors++; $display("FAIL iso_grant got g=%0d iso=%b exp 2 1", Grant, IN_Isochronous); end
        tick();
        Req_Ready = 4'b0000;
        tick();
        #1;
        checks++; if (Busy !== 1'b0 || Req_Ack !== 4'b0000 || Timeout !== 1'b0) begin errors++; $display("FAIL iso_release got busy=%b ack=%b to=%b exp 0 0000 0", Busy, Req_Ack, Timeout); end
        tick();
        #1;
        checks++; if (Timeout !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL iso_quiet got to=%b busy=%b exp 0 0", Timeout, Busy); end
        Req_Isochronous = 4'b0000;
        $display("txn isochronous src2");
    endtask

    task automatic test_timeout();
        Req_Ready = 4'b0011;
        tick();
        #1;
        checks++; if (Grant !== 2'd0) begin errors++; $display("FAIL to_grant got g=%0d exp 0", Grant); end
        tick();
        Req_Ready = 4'b0010;
        tick();
        for (int k = 1; k <= 17; k++) begin
            tick();
            checks++; if (Timeout !== (k == 16)) begin errors++; $display("FAIL to_cycle%0d got to=%b exp %b", k, Timeout, (k == 16)); end
            if (k == 16) begin
                checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL to_idle got busy=%b exp 0", Busy); end
            end
        end
        checks++; if (Grant !== 2'd1 || Busy !== 1'b1 || IN_Ready !== 1'b1) begin errors++; $display("FAIL to_next got g=%0d busy=%b rdy=%b exp 1 1 1", Grant, Busy, IN_Ready); end
        $display("txn timeout src0 then src1 granted");
    endtask

    task automatic test_reset_mid();
        IN_WaitRequest = 1'b1;
        #1;
        checks++; if (IN_Ready !== 1'b1 || Req_WaitRequest !== 4'hF) begin errors++; $display("FAIL rst_pre got rdy=%b wr=%b exp 1 1111", IN_Ready, Req_WaitRequest); end
        #1;
        Reset = 1'b0;
        #1;
        checks++; if (IN_Ready !== 1'b0 || Busy !== 1'b0 || Grant !== 2'd0) begin errors++; $display("FAIL rst_async got rdy=%b busy=%b g=%0d exp 0 0 0", IN_Ready, Busy, Grant); end
        Reset = 1'b1;
        IN_WaitRequest = 1'b0;
        Req_Ready = 4'b0011;
        tick();
        #1;
        checks++; if (Grant !== 2'd0 || IN_Ready !== 1'b1) begin errors++; $display("FAIL rst_first got g=%0d rdy=%b exp 0 1", Grant, IN_Ready); end
        $display("txn reset mid packet");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_error_retry();
        test_isochronous();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
